// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall, flush and forwarding control for a five-stage pipeline, with an MDU busy countdown and event counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_mdu_read,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mdu_start,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  input  logic                  mem_pc_src,
  input  logic                  cnt_clr,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  id_byp_a,
  output logic                  id_byp_b,
  output logic                  mdu_busy,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  localparam int MW = $clog2(MDU_LATENCY + 1);
  logic [MW-1:0] mdu_cnt;
  logic load_haz, mdu_haz, stall, wb_ok, mem_ok;
  assign load_haz = ex_mem_read && ex_rd != '0 &&
                    ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  assign mdu_busy = mdu_cnt != '0;
  assign mdu_haz = id_mdu_read && mdu_busy;
  // a taken branch squashes the stalled instruction anyway, so it wins
  assign stall = !mem_pc_src && (load_haz || mdu_haz);
  assign pc_write = !stall;
  assign ifid_write = !stall;
  assign ifid_flush = mem_pc_src;
  assign idex_flush = mem_pc_src || stall;
  assign exmem_flush = mem_pc_src;
  assign mem_ok = mem_reg_write && mem_rd != '0;
  assign wb_ok = wb_reg_write && wb_rd != '0;
  assign fwd_a = (mem_ok && mem_rd == ex_rs) ? 2'b10 : (wb_ok && wb_rd == ex_rs) ? 2'b01 : 2'b00;
  assign fwd_b = (mem_ok && mem_rd == ex_rt) ? 2'b10 : (wb_ok && wb_rd == ex_rt) ? 2'b01 : 2'b00;
  assign id_byp_a = wb_ok && wb_rd == id_rs;
  assign id_byp_b = wb_ok && wb_rd == id_rt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdu_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      mdu_cnt <= (ex_mdu_start && !mem_pc_src) ? MW'(MDU_LATENCY) : mdu_busy ? mdu_cnt - 1'b1 : mdu_cnt;
      stall_cnt <= cnt_clr ? '0 : (stall && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
      flush_cnt <= cnt_clr ? '0 : (mem_pc_src && flush_cnt != '1) ? flush_cnt + 1'b1 : flush_cnt;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: vector table, directed corner sequences and random stimulus against a behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int LAT = 4;
  typedef struct {
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rs, id_uses_rt, id_mdu_read;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic       ex_reg_write, ex_mem_read, ex_mdu_start;
    logic [4:0] mem_rd, wb_rd;
    logic       mem_reg_write, wb_reg_write, mem_pc_src, cnt_clr;
  } in_t;
  typedef struct {
    string      name;
    in_t        i;
    logic       pc_write, idex_flush, byp_a;
    logic [1:0] fa, fb;
  } vec_t;

  logic clk = 0, rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs, id_uses_rt, id_mdu_read, ex_reg_write, ex_mem_read, ex_mdu_start;
  logic mem_reg_write, wb_reg_write, mem_pc_src, cnt_clr;
  logic pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, id_byp_a, id_byp_b, mdu_busy;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_exmem_flush, s_byp_a, s_byp_b, s_busy;
  logic [1:0] s_fwd_a, s_fwd_b, s_stall_cnt, s_flush_cnt;

  int total = 0, bad = 0;
  int m_mdu = 0, m_stall = 0, m_flush = 0, m_stall2 = 0, m_flush2 = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MDU_LATENCY(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_mdu_read(id_mdu_read), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mdu_start(ex_mdu_start), .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .mem_pc_src(mem_pc_src), .cnt_clr(cnt_clr),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .id_byp_a(id_byp_a), .id_byp_b(id_byp_b), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MDU_LATENCY(LAT), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_mdu_read(id_mdu_read), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mdu_start(ex_mdu_start), .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .mem_pc_src(mem_pc_src), .cnt_clr(cnt_clr),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
    .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .id_byp_a(s_byp_a), .id_byp_b(s_byp_b), .mdu_busy(s_busy),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t v);
    id_rs = v.id_rs; id_rt = v.id_rt; id_uses_rs = v.id_uses_rs; id_uses_rt = v.id_uses_rt;
    id_mdu_read = v.id_mdu_read; ex_rs = v.ex_rs; ex_rt = v.ex_rt; ex_rd = v.ex_rd;
    ex_reg_write = v.ex_reg_write; ex_mem_read = v.ex_mem_read; ex_mdu_start = v.ex_mdu_start;
    mem_rd = v.mem_rd; wb_rd = v.wb_rd; mem_reg_write = v.mem_reg_write;
    wb_reg_write = v.wb_reg_write; mem_pc_src = v.mem_pc_src; cnt_clr = v.cnt_clr;
  endtask

  function automatic int sel(input logic mw, input logic [4:0] md, input logic ww,
                             input logic [4:0] wd, input logic [4:0] src);
    if (mw && md != 0 && md == src) return 2;
    if (ww && wd != 0 && wd == src) return 1;
    return 0;
  endfunction

  // checks every output against the model, then advances the model across one clock edge
  task automatic finish(input in_t v);
    bit busy, load, stl, br;
    busy = m_mdu > 0;
    br = v.mem_pc_src;
    load = v.ex_mem_read && v.ex_rd != 0 &&
           ((v.id_uses_rs && v.id_rs == v.ex_rd) || (v.id_uses_rt && v.id_rt == v.ex_rd));
    stl = !br && (load || (v.id_mdu_read && busy));
    chk("pc_write", pc_write, !stl);
    chk("ifid_write", ifid_write, !stl);
    chk("ifid_flush", ifid_flush, br);
    chk("idex_flush", idex_flush, br || stl);
    chk("exmem_flush", exmem_flush, br);
    chk("fwd_a", fwd_a, sel(v.mem_reg_write, v.mem_rd, v.wb_reg_write, v.wb_rd, v.ex_rs));
    chk("fwd_b", fwd_b, sel(v.mem_reg_write, v.mem_rd, v.wb_reg_write, v.wb_rd, v.ex_rt));
    chk("id_byp_a", id_byp_a, v.wb_reg_write && v.wb_rd != 0 && v.wb_rd == v.id_rs);
    chk("id_byp_b", id_byp_b, v.wb_reg_write && v.wb_rd != 0 && v.wb_rd == v.id_rt);
    chk("mdu_busy", mdu_busy, busy);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    chk("sat_stall_cnt", s_stall_cnt, m_stall2);
    chk("sat_flush_cnt", s_flush_cnt, m_flush2);
    @(posedge clk);
    m_mdu = (v.ex_mdu_start && !br) ? LAT : (m_mdu > 0 ? m_mdu - 1 : 0);
    m_stall = v.cnt_clr ? 0 : (stl ? (m_stall < 65535 ? m_stall + 1 : m_stall) : m_stall);
    m_flush = v.cnt_clr ? 0 : (br ? (m_flush < 65535 ? m_flush + 1 : m_flush) : m_flush);
    m_stall2 = v.cnt_clr ? 0 : (stl ? (m_stall2 < 3 ? m_stall2 + 1 : m_stall2) : m_stall2);
    m_flush2 = v.cnt_clr ? 0 : (br ? (m_flush2 < 3 ? m_flush2 + 1 : m_flush2) : m_flush2);
    @(negedge clk);
  endtask

  task automatic step(input in_t v);
    drive(v);
    #1;
    finish(v);
  endtask

  initial begin
    in_t z, v;
    vec_t tbl[$];
    vec_t e;
    int busy_n, stall_n, base;
    z = '{default: '0};
    drive(z);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("reset_pc_write", pc_write, 1);
    chk("reset_mdu_busy", mdu_busy, 0);
    chk("reset_stall_cnt", stall_cnt, 0);

    e = '{name: "load_use_rs", i: z, pc_write: 0, idex_flush: 1, byp_a: 0, fa: 0, fb: 0};
    e.i.ex_mem_read = 1; e.i.ex_rd = 5; e.i.id_rs = 5; e.i.id_uses_rs = 1; tbl.push_back(e);
    e.name = "load_rd_zero"; e.i.ex_rd = 0; e.i.id_rs = 0; e.pc_write = 1; e.idex_flush = 0; tbl.push_back(e);
    e = '{name: "fwd_mem_prio", i: z, pc_write: 1, idex_flush: 0, byp_a: 0, fa: 2, fb: 0};
    e.i.ex_rs = 3; e.i.mem_rd = 3; e.i.wb_rd = 3; e.i.mem_reg_write = 1; e.i.wb_reg_write = 1; tbl.push_back(e);
    e.name = "fwd_wb"; e.i.mem_reg_write = 0; e.fa = 1; tbl.push_back(e);
    e = '{name: "fwd_zero_dst", i: z, pc_write: 1, idex_flush: 0, byp_a: 0, fa: 0, fb: 0};
    e.i.ex_rt = 3; e.i.mem_reg_write = 1; e.i.wb_reg_write = 1; tbl.push_back(e);
    e = '{name: "fwd_b_mem", i: z, pc_write: 1, idex_flush: 0, byp_a: 0, fa: 0, fb: 2};
    e.i.ex_rt = 6; e.i.mem_rd = 6; e.i.mem_reg_write = 1; tbl.push_back(e);
    e = '{name: "id_bypass", i: z, pc_write: 1, idex_flush: 0, byp_a: 1, fa: 0, fb: 0};
    e.i.id_rs = 7; e.i.wb_rd = 7; e.i.wb_reg_write = 1; tbl.push_back(e);
    e = '{name: "load_unused_rs", i: z, pc_write: 1, idex_flush: 0, byp_a: 0, fa: 0, fb: 0};
    e.i.ex_mem_read = 1; e.i.ex_rd = 9; e.i.id_rs = 9; tbl.push_back(e);
    e.name = "load_use_rt"; e.i.id_rs = 0; e.i.id_rt = 9; e.i.id_uses_rt = 1;
    e.pc_write = 0; e.idex_flush = 1; tbl.push_back(e);

    foreach (tbl[k]) begin
      drive(tbl[k].i);
      #1;
      chk({tbl[k].name, ".pc_write"}, pc_write, tbl[k].pc_write);
      chk({tbl[k].name, ".idex_flush"}, idex_flush, tbl[k].idex_flush);
      chk({tbl[k].name, ".fwd_a"}, fwd_a, tbl[k].fa);
      chk({tbl[k].name, ".fwd_b"}, fwd_b, tbl[k].fb);
      chk({tbl[k].name, ".byp_a"}, id_byp_a, tbl[k].byp_a);
      finish(tbl[k].i);
    end
    chk("load_use_stall_cnt", stall_cnt, 2);

    // MDU latency: busy and stalled for exactly LAT cycles
    base = m_stall;
    v = z; v.ex_mdu_start = 1; step(v);
    v = z; v.id_mdu_read = 1;
    busy_n = 0; stall_n = 0;
    repeat (LAT + 2) begin
      drive(v); #1;
      busy_n += mdu_busy; stall_n += !pc_write;
      finish(v);
    end
    chk("mdu_busy_cycles", busy_n, LAT);
    chk("mdu_stall_cycles", stall_n, LAT);
    chk("mdu_stall_cnt", stall_cnt, base + LAT);

    // restart at count 2 gives LAT more busy cycles after the restart edge
    v = z; v.ex_mdu_start = 1; step(v);
    step(z); step(z);
    step(v);
    busy_n = 0;
    repeat (LAT + 3) begin
      drive(z); #1; busy_n += mdu_busy; finish(z);
    end
    chk("mdu_restart_busy", busy_n, LAT);

    // branch wins over load-use, and squashes a same-cycle MDU start
    base = m_stall;
    v = z; v.ex_mem_read = 1; v.ex_rd = 4; v.id_rs = 4; v.id_uses_rs = 1;
    v.mem_pc_src = 1; v.ex_mdu_start = 1;
    drive(v); #1;
    chk("br_ifid_flush", ifid_flush, 1);
    chk("br_exmem_flush", exmem_flush, 1);
    chk("br_pc_write", pc_write, 1);
    finish(v);
    #1;
    chk("br_mdu_squashed", mdu_busy, 0);
    chk("br_stall_unchanged", stall_cnt, base);

    // saturation on the 2-bit instance, then clear beats increment
    v = z; v.cnt_clr = 1; step(v);
    v = z; v.mem_pc_src = 1;
    repeat (5) step(v);
    chk("sat_flush_3", s_flush_cnt, 3);
    v.cnt_clr = 1; step(v);
    chk("clr_over_branch", s_flush_cnt, 0);
    chk("clr_over_branch_wide", flush_cnt, 0);

    // asynchronous reset while the MDU is counting
    v = z; v.mem_pc_src = 1; step(v);
    v = z; v.ex_mdu_start = 1; step(v);
    step(z); step(z);
    #2 rst = 1;
    #1;
    chk("rst_async_busy", mdu_busy, 0);
    chk("rst_async_flush_cnt", flush_cnt, 0);
    chk("rst_async_stall_cnt", stall_cnt, 0);
    m_mdu = 0; m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
    @(negedge clk);
    rst = 0;
    v = z; v.id_mdu_read = 1;
    drive(v); #1;
    chk("post_rst_no_stall", pc_write, 1);
    finish(v);

    repeat (400) begin
      v.id_rs = 5'($urandom_range(0, 3)); v.id_rt = 5'($urandom_range(0, 3));
      v.id_uses_rs = 1'($urandom); v.id_uses_rt = 1'($urandom); v.id_mdu_read = 1'($urandom);
      v.ex_rs = 5'($urandom_range(0, 3)); v.ex_rt = 5'($urandom_range(0, 3));
      v.ex_rd = 5'($urandom_range(0, 3)); v.ex_reg_write = 1'($urandom);
      v.ex_mem_read = 1'($urandom); v.ex_mdu_start = ($urandom_range(0, 7) == 0);
      v.mem_rd = 5'($urandom_range(0, 3)); v.wb_rd = 5'($urandom_range(0, 3));
      v.mem_reg_write = 1'($urandom); v.wb_reg_write = 1'($urandom);
      v.mem_pc_src = ($urandom_range(0, 7) == 0); v.cnt_clr = ($urandom_range(0, 31) == 0);
      step(v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
